alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Control-side initiator for the nibble-serial ALU block. It accepts one 8-bit operation request, drives the ALU control strobes in the required order (load OP1, load OP2 plus low-nibble compute, high-nibble compute) and collects the result and the F-register flag bits. It sits between the instruction decoder and the ALU, replacing ad-hoc strobe generation with one fixed 4-cycle schedule.

Parameters:
None. All operation encodings are fixed by this specification.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  3  0=ADD 1=ADC 2=SUB 3=SBC 4=AND 5=XOR 6=OR 7=CP
cin  in  1  carry flag input, used by ADC/SBC
opa  in  8  operand 1
opb  in  8  operand 2
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; result and flags valid from this cycle
result  out  8  ALU result, held until the next done
res_we  out  1  qualifies result with done; 0 for CP
cf_o, hf_o, pf_o, zf_o, sf_o, vf_o, nf_o  out  1 each  flags, held until the next done
db_out  out  8  value driven onto the ALU external bus
db_oe  out  1  sequencer drives db_out
db_in  in  8  ALU external bus readback
alu_oe, alu_shift_oe, alu_res_oe, alu_op1_sel_bus, alu_op2_sel_bus, alu_op_low, alu_sel_op2_high, alu_sel_op2_neg, alu_core_cf_in, alu_core_R, alu_core_S, alu_core_V, alu_parity_in  out  1 each  ALU controls
alu_core_cf_out, alu_parity_out, alu_zero, alu_sf_out, alu_vf_out  in  1 each  ALU status

Behaviour:
- States: IDLE, LD1, LD2, HIGH, DONE. Encoding is free.
- Reset: state goes to IDLE. Every output and internal register is cleared to 0, including result, all flags, busy, done and db_oe.
- Reset mid-operation: abort immediately. No done pulse. Outputs and flags are cleared.
- Transitions:
  - IDLE -> LD1 when start=1. On that edge, capture op, cin, opa and opb.
  - LD1 -> LD2 -> HIGH -> DONE -> IDLE, each unconditional.
- Timing:
  - done is high in the DONE state, which is the 4th cycle after the start edge.
  - busy is high in LD1, LD2 and HIGH.
  - A start pulse in any state other than IDLE is ignored. Back-to-back operation is allowed: start may be sampled in the cycle after DONE.
- LD1:
  - db_oe=1, db_out=opa.
  - alu_shift_oe=1, alu_op1_sel_bus=1.
- LD2:
  - db_oe=1, db_out=opb.
  - alu_shift_oe=1, alu_op2_sel_bus=1, alu_op_low=1.
  - alu_sel_op2_high=0, alu_parity_in=0.
  - alu_core_cf_in = c0, where c0 is:
    - 0 for ADD, AND, XOR, OR;
    - cin for ADC;
    - 1 for SUB and CP;
    - ~cin for SBC.
  - At the end of LD2, register hc=alu_core_cf_out and plo=alu_parity_out.
- HIGH:
  - db_oe=0, alu_op_low=0, alu_sel_op2_high=1.
  - alu_core_cf_in=hc, alu_parity_in=plo.
  - alu_res_oe=1, alu_oe=1.
  - At the end of HIGH, register:
    - result=db_in;
    - cf_o = alu_core_cf_out XOR sub;
    - hf_o = hc XOR sub;
    - pf_o = alu_parity_out for logic ops, alu_vf_out for arithmetic ops;
    - zf_o = alu_zero;
    - sf_o = alu_sf_out;
    - vf_o = alu_vf_out (arithmetic ops only);
    - nf_o = sub.
  - sub=1 for SUB, SBC and CP.
- alu_sel_op2_neg=1 in LD2 and HIGH when sub=1.
- R/S/V outputs are held for LD2 and HIGH:
  - arithmetic ops: 000;
  - AND: 010;
  - OR: 110;
  - XOR: 001.
- Logic-op flags:
  - cf_o=0, nf_o=0.
  - hf_o=1 for AND, 0 for XOR and OR.
- CP: flags update as for SUB; res_we=0 on done; the result register is unchanged.
- All ALU control outputs are 0 in IDLE and DONE. At most one of alu_shift_oe and alu_res_oe is high in any cycle.
- Width rule: all arithmetic is modulo 256. Borrow is reported as the complemented carry.

Test Plan:
1. ADD opa=8C opb=68 -> done 4 cycles after start; result=F4, cf=0, hf=1, sf=1, zf=0, nf=0, vf=0.
2. SUB opa=10 opb=01 -> result=0F, hf=1, cf=0, nf=1, zf=0.
3. SBC cin=1 opa=00 opb=00 -> result=FF, cf=1, hf=1, sf=1. Then ADC cin=1 opa=FF opb=00 -> result=00, zf=1, cf=1.
4. CP opa=5A opb=5A -> zf=1, nf=1, res_we=0; result keeps its previous value. XOR opa=F0 opb=0F -> result=FF, pf=1, cf=0.
5. Assert start on the DONE cycle -> accepted, with a second done exactly 5 cycles after the first. A start pulse during LD2 -> ignored, and only one done is produced.
6. Assert reset during HIGH -> IDLE at once; all outputs 0, no done. After reset is released, ADD 01+01 -> result=02.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: control-side initiator for the nibble-serial ALU.
// One request runs a fixed LD1 -> LD2 -> HIGH -> DONE schedule. Along the way
// it strobes the ALU, chains the low-nibble carry/parity into the high nibble,
// and captures the result byte and the F-register flags.
module alu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       cin,
    input  logic [7:0] opa,
    input  logic [7:0] opb,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       res_we,
    output logic       cf_o,
    output logic       hf_o,
    output logic       pf_o,
    output logic       zf_o,
    output logic       sf_o,
    output logic       vf_o,
    output logic       nf_o,
    output logic [7:0] db_out,
    output logic       db_oe,
    input  logic [7:0] db_in,
    output logic       alu_oe,
    output logic       alu_shift_oe,
    output logic       alu_res_oe,
    output logic       alu_op1_sel_bus,
    output logic       alu_op2_sel_bus,
    output logic       alu_op_low,
    output logic       alu_sel_op2_high,
    output logic       alu_sel_op2_neg,
    output logic       alu_core_cf_in,
    output logic       alu_core_R,
    output logic       alu_core_S,
    output logic       alu_core_V,
    output logic       alu_parity_in,
    input  logic       alu_core_cf_out,
    input  logic       alu_parity_out,
    input  logic       alu_zero,
    input  logic       alu_sf_out,
    input  logic       alu_vf_out
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LD1  = 3'd1;
    localparam logic [2:0] S_LD2  = 3'd2;
    localparam logic [2:0] S_HIGH = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    // Carry into the low nibble. Subtraction is done as A + ~B + 1, so a
    // borrow-in flips the seed.
    function automatic logic carry_seed(input logic [2:0] o, input logic c);
        case (o)
            OP_ADC:        carry_seed = c;
            OP_SUB, OP_CP: carry_seed = 1'b1;
            OP_SBC:        carry_seed = ~c;
            default:       carry_seed = 1'b0;
        endcase
    endfunction

    // Core function select {R,S,V}. Arithmetic ops all use the adder.
    function automatic logic [2:0] core_mode(input logic [2:0] o);
        case (o)
            OP_AND:  core_mode = 3'b010;
            OP_OR:   core_mode = 3'b110;
            OP_XOR:  core_mode = 3'b001;
            default: core_mode = 3'b000;
        endcase
    endfunction

    logic [2:0] state_q, state_d;
    logic [2:0] op_q, op_d;
    logic       cin_q, cin_d;
    logic [7:0] opa_q, opa_d;
    logic [7:0] opb_q, opb_d;
    logic       hc_q, hc_d;
    logic       plo_q, plo_d;
    logic [7:0] result_q, result_d;
    // Packed as {cf, hf, pf, zf, sf, vf, nf}
    logic [6:0] flags_q, flags_d;

    logic is_sub;
    logic is_logic;
    logic is_and;
    logic is_cp;

    assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
    assign is_logic = (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_OR);
    assign is_and   = (op_q == OP_AND);
    assign is_cp    = (op_q == OP_CP);

    // Next-state and capture logic: request latch, nibble chaining, result/flag capture
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cin_d    = cin_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        hc_d     = hc_q;
        plo_d    = plo_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LD1;
                    op_d    = op;
                    cin_d   = cin;
                    opa_d   = opa;
                    opb_d   = opb;
                end
            end
            S_LD1: state_d = S_LD2;
            S_LD2: begin
                state_d = S_HIGH;
                hc_d    = alu_core_cf_out;
                plo_d   = alu_parity_out;
            end
            S_HIGH: begin
                state_d = S_DONE;
                // CP only sets flags; the accumulator copy stays as it was.
                if (!is_cp) begin
                    result_d = db_in;
                end
                if (is_logic) begin
                    flags_d = {1'b0, is_and, alu_parity_out, alu_zero, alu_sf_out, 1'b0, 1'b0};
                end else begin
                    // Carry out of an A + ~B + 1 subtract is the inverted borrow.
                    flags_d = {alu_core_cf_out ^ is_sub, hc_q ^ is_sub, alu_vf_out,
                               alu_zero, alu_sf_out, alu_vf_out, is_sub};
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            cin_q    <= 1'b0;
            opa_q    <= 8'h00;
            opb_q    <= 8'h00;
            hc_q     <= 1'b0;
            plo_q    <= 1'b0;
            result_q <= 8'h00;
            flags_q  <= 7'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cin_q    <= cin_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            hc_q     <= hc_d;
            plo_q    <= plo_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // ALU strobe decode; shift_oe (LD1/LD2) and res_oe (HIGH) never overlap
    always_comb begin
        db_out           = 8'h00;
        db_oe            = 1'b0;
        alu_oe           = 1'b0;
        alu_shift_oe     = 1'b0;
        alu_res_oe       = 1'b0;
        alu_op1_sel_bus  = 1'b0;
        alu_op2_sel_bus  = 1'b0;
        alu_op_low       = 1'b0;
        alu_sel_op2_high = 1'b0;
        alu_sel_op2_neg  = 1'b0;
        alu_core_cf_in   = 1'b0;
        alu_core_R       = 1'b0;
        alu_core_S       = 1'b0;
        alu_core_V       = 1'b0;
        alu_parity_in    = 1'b0;
        case (state_q)
            S_LD1: begin
                db_oe           = 1'b1;
                db_out          = opa_q;
                alu_shift_oe    = 1'b1;
                alu_op1_sel_bus = 1'b1;
            end
            S_LD2: begin
                db_oe           = 1'b1;
                db_out          = opb_q;
                alu_shift_oe    = 1'b1;
                alu_op2_sel_bus = 1'b1;
                alu_op_low      = 1'b1;
                alu_sel_op2_neg = is_sub;
                alu_core_cf_in  = carry_seed(op_q, cin_q);
                {alu_core_R, alu_core_S, alu_core_V} = core_mode(op_q);
            end
            S_HIGH: begin
                alu_sel_op2_high = 1'b1;
                alu_sel_op2_neg  = is_sub;
                alu_core_cf_in   = hc_q;
                alu_parity_in    = plo_q;
                alu_res_oe       = 1'b1;
                alu_oe           = 1'b1;
                {alu_core_R, alu_core_S, alu_core_V} = core_mode(op_q);
            end
            default: begin
            end
        endcase
    end

    assign busy   = (state_q == S_LD1) || (state_q == S_LD2) || (state_q == S_HIGH);
    assign done   = (state_q == S_DONE);
    assign res_we = (state_q == S_DONE) && !is_cp;
    assign result = result_q;
    assign {cf_o, hf_o, pf_o, zf_o, sf_o, vf_o, nf_o} = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors against alu_sequencer with a small
// behavioural nibble-serial ALU attached. Expected results are queued at issue
// time, and a negedge monitor pops and compares them on every done pulse.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic       cin;
    logic [7:0] opa, opb;
    logic       busy, done, res_we;
    logic [7:0] result;
    logic       cf_o, hf_o, pf_o, zf_o, sf_o, vf_o, nf_o;
    logic [7:0] db_out, db_in;
    logic       db_oe;
    logic       alu_oe, alu_shift_oe, alu_res_oe, alu_op1_sel_bus, alu_op2_sel_bus;
    logic       alu_op_low, alu_sel_op2_high, alu_sel_op2_neg, alu_core_cf_in;
    logic       alu_core_R, alu_core_S, alu_core_V, alu_parity_in;
    logic       alu_core_cf_out, alu_parity_out, alu_zero, alu_sf_out, alu_vf_out;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .cin(cin),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
        .res_we(res_we), .cf_o(cf_o), .hf_o(hf_o), .pf_o(pf_o), .zf_o(zf_o),
        .sf_o(sf_o), .vf_o(vf_o), .nf_o(nf_o), .db_out(db_out), .db_oe(db_oe),
        .db_in(db_in), .alu_oe(alu_oe), .alu_shift_oe(alu_shift_oe),
        .alu_res_oe(alu_res_oe), .alu_op1_sel_bus(alu_op1_sel_bus),
        .alu_op2_sel_bus(alu_op2_sel_bus), .alu_op_low(alu_op_low),
        .alu_sel_op2_high(alu_sel_op2_high), .alu_sel_op2_neg(alu_sel_op2_neg),
        .alu_core_cf_in(alu_core_cf_in), .alu_core_R(alu_core_R),
        .alu_core_S(alu_core_S), .alu_core_V(alu_core_V),
        .alu_parity_in(alu_parity_in), .alu_core_cf_out(alu_core_cf_out),
        .alu_parity_out(alu_parity_out), .alu_zero(alu_zero),
        .alu_sf_out(alu_sf_out), .alu_vf_out(alu_vf_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural nibble-serial ALU
    logic [7:0] m_op1 = 8'h00, m_op2 = 8'h00, m_b;
    logic [3:0] m_lo = 4'h0, m_an, m_bn, m_nib;
    logic [4:0] m_sum;
    logic [3:0] m_s3;
    logic       m_arith;

    always @(posedge clk) begin
        if (alu_shift_oe && alu_op1_sel_bus) m_op1 <= db_out;
        if (alu_shift_oe && alu_op2_sel_bus) m_op2 <= db_out;
        if (alu_op_low) m_lo <= m_nib;
    end

    always_comb begin
        m_b = alu_op2_sel_bus ? db_out : m_op2;
        if (alu_sel_op2_neg) m_b = ~m_b;
        m_an  = alu_sel_op2_high ? m_op1[7:4] : m_op1[3:0];
        m_bn  = alu_sel_op2_high ? m_b[7:4]   : m_b[3:0];
        m_sum = {1'b0, m_an} + {1'b0, m_bn} + {4'b0, alu_core_cf_in};
        m_s3  = {1'b0, m_an[2:0]} + {1'b0, m_bn[2:0]} + {3'b0, alu_core_cf_in};
        m_arith = 1'b0;
        case ({alu_core_R, alu_core_S, alu_core_V})
            3'b010:  m_nib = m_an & m_bn;
            3'b110:  m_nib = m_an | m_bn;
            3'b001:  m_nib = m_an ^ m_bn;
            default: begin m_nib = m_sum[3:0]; m_arith = 1'b1; end
        endcase
        alu_core_cf_out = m_arith & m_sum[4];
        alu_vf_out      = m_arith & (m_s3[3] ^ m_sum[4]);
        // Even-parity flag: seeded by the low nibble, chained through parity_in.
        alu_parity_out  = alu_op_low ? ~(^m_nib) : (alu_parity_in ^ (^m_nib));
        alu_zero        = ({m_nib, m_lo} == 8'h00);
        alu_sf_out      = m_nib[3];
        db_in           = alu_oe ? {m_nib, m_lo} : 8'h00;
    end

    logic [39:0] outs;
    assign outs = {busy, done, result, res_we, cf_o, hf_o, pf_o, zf_o, sf_o, vf_o, nf_o,
                   db_out, db_oe, alu_oe, alu_shift_oe, alu_res_oe, alu_op1_sel_bus,
                   alu_op2_sel_bus, alu_op_low, alu_sel_op2_high, alu_sel_op2_neg,
                   alu_core_cf_in, alu_core_R, alu_core_S, alu_core_V, alu_parity_in};

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] res;
        logic       we;
        logic [6:0] flg;
        int         dcyc;
        string      name;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            check("strobe_excl", 40'(alu_shift_oe & alu_res_oe), 40'd0);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 40'd1, 40'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_cycle"}, 40'(cyc), 40'(e.dcyc));
                    check({e.name, "_result"}, 40'(result), 40'(e.res));
                    check({e.name, "_res_we"}, 40'(res_we), 40'(e.we));
                    check({e.name, "_flags"}, 40'({cf_o, hf_o, pf_o, zf_o, sf_o, vf_o, nf_o}),
                          40'(e.flg));
                    check({e.name, "_busy"}, 40'(busy), 40'd0);
                end
            end
        end
    end

    // Present a request, hold start for 'holds' edges, queue the expectation.
    task automatic issue(input logic [2:0] o, input logic c, input logic [7:0] a,
                         input logic [7:0] b, input int holds, input bit push,
                         input logic [7:0] xr, input logic xwe, input logic [6:0] xf,
                         input string nm, output int acc);
        op = o; cin = c; opa = a; opb = b; start = 1'b1;
        for (int i = 0; i < holds; i++) @(posedge clk);
        #1;
        start = 1'b0;
        acc = cyc;
        check({nm, "_busy_ld1"}, 40'(busy), 40'd1);
        if (push) sb.push_back('{xr, xwe, xf, acc + 3, nm});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) check("done_timeout", 40'(sb.size()), 40'd0);
        @(posedge clk);
        #1;
    endtask

    int acc;

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; cin = 1'b0; opa = 8'h00; opb = 8'h00;
        #12;
        check("reset_outputs", outs, 40'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", outs, 40'd0);

        // flag order {cf,hf,pf,zf,sf,vf,nf}
        issue(3'd0, 1'b0, 8'h8C, 8'h68, 1, 1'b1, 8'hF4, 1'b1, 7'b0100100, "add_8c_68", acc);
        wait_idle();
        issue(3'd2, 1'b0, 8'h10, 8'h01, 1, 1'b1, 8'h0F, 1'b1, 7'b0100001, "sub_10_01", acc);
        wait_idle();
        issue(3'd3, 1'b1, 8'h00, 8'h00, 1, 1'b1, 8'hFF, 1'b1, 7'b1100101, "sbc_00_00", acc);
        wait_idle();
        issue(3'd1, 1'b1, 8'hFF, 8'h00, 1, 1'b1, 8'h00, 1'b1, 7'b1101000, "adc_ff_00", acc);
        wait_idle();
        issue(3'd7, 1'b0, 8'h5A, 8'h5A, 1, 1'b1, 8'h00, 1'b0, 7'b0001001, "cp_5a_5a", acc);
        wait_idle();
        issue(3'd5, 1'b0, 8'hF0, 8'h0F, 1, 1'b1, 8'hFF, 1'b1, 7'b0010100, "xor_f0_0f", acc);
        wait_idle();
        issue(3'd4, 1'b0, 8'hF0, 8'h3C, 1, 1'b1, 8'h30, 1'b1, 7'b0110000, "and_f0_3c", acc);
        wait_idle();
        issue(3'd6, 1'b0, 8'h81, 8'h02, 1, 1'b1, 8'h83, 1'b1, 7'b0000100, "or_81_02", acc);
        wait_idle();

        // Back-to-back: start raised in the DONE cycle, taken in the following IDLE
        issue(3'd0, 1'b0, 8'h01, 8'h02, 1, 1'b1, 8'h03, 1'b1, 7'b0000000, "b2b_first", acc);
        repeat (3) @(posedge clk);
        #1;
        issue(3'd0, 1'b0, 8'h7F, 8'h01, 2, 1'b1, 8'h80, 1'b1, 7'b0110110, "b2b_second", acc);
        wait_idle();

        // Start pulse during LD2 must be ignored
        issue(3'd2, 1'b0, 8'h05, 8'h03, 1, 1'b1, 8'h02, 1'b1, 7'b0000001, "sub_ld2_pulse", acc);
        @(posedge clk); #1;
        op = 3'd0; opa = 8'hFF; opb = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (8) @(posedge clk);
        #1;
        check("ld2_pulse_idle", 40'(busy), 40'd0);

        // Reset in HIGH aborts without a done pulse
        issue(3'd0, 1'b0, 8'h33, 8'h44, 1, 1'b0, 8'h00, 1'b0, 7'b0, "aborted", acc);
        @(posedge clk);
        @(posedge clk); #1;
        check("in_high_res_oe", 40'(alu_res_oe), 40'd1);
        reset = 1'b1;
        #1;
        check("abort_outputs", outs, 40'd0);
        @(posedge clk);
        @(negedge clk); reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("post_abort_outputs", outs, 40'd0);
        issue(3'd0, 1'b0, 8'h01, 8'h01, 1, 1'b1, 8'h02, 1'b1, 7'b0000000, "add_after_reset", acc);
        wait_idle();

        check("scoreboard_empty", 40'(sb.size()), 40'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
